retospect_bs_loader: RTL

Serial configuration writer for the neurochip config chain (clockbox followed by X_MAX*Y_MAX cnb cells).
- Accepts configuration bytes over a valid/ready stream.
- Serialises them LSB-first onto the chain's config_en/bs_in pair.
- Reassembles the bits returning from the chain tail (bs_out) into readback bytes, so a full load also reads back the previous configuration.
- Sits between the host-facing pins and the chain head; replaces direct pin-driven bit banging.

---
 rtl/retospect_bs_loader_pkg.sv | 20 ++
 rtl/retospect_bs_loader_deser.sv | 66 ++++++
 rtl/retospect_bs_loader.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/retospect_bs_loader_pkg.sv
// Shared definitions for the neurochip configuration chain loader.
//   CHAIN_BITS_CLOCKBOX / CHAIN_BITS_CELL : bit counts of the chain segments
//   chain_len(x, y)                       : total chain bits for an x*y array
//   state_e                               : loader controller states
package retospect_pkg;

    localparam int CHAIN_BITS_CLOCKBOX = 48;
    localparam int CHAIN_BITS_CELL     = 21;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    function automatic int chain_len(input int x, input int y);
        return CHAIN_BITS_CLOCKBOX + x * y * CHAIN_BITS_CELL;
    endfunction

endpackage

// File: rtl/retospect_bs_loader_deser.sv
// Readback byte assembler for bits returning from the chain tail.
//   i_sample_en : capture i_bit_in this edge
//   i_bit_in    : returning serial bit (first bit ends up in o_byte[0])
//   i_flush     : last sample of the load; emit any partial byte right-justified
//   i_clear     : drop everything, no output
//   o_byte      : assembled byte
//   o_valid     : one-cycle pulse, o_byte valid
module retospect_bs_deser (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sample_en,
    input  logic       i_bit_in,
    input  logic       i_flush,
    input  logic       i_clear,
    output logic [7:0] o_byte,
    output logic       o_valid
);

    logic [7:0] r_sr;
    logic [3:0] r_cnt;
    logic [7:0] r_byte;
    logic       r_valid;
    logic [7:0] w_sr_nxt;
    logic [3:0] w_cnt_nxt;

    // New bits enter at the MSB so after 8 samples the first one sits at bit 0.
    assign w_sr_nxt  = i_sample_en ? {i_bit_in, r_sr[7:1]} : r_sr;
    assign w_cnt_nxt = r_cnt + 4'(i_sample_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr    <= '0;
            r_cnt   <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_sr    <= '0;
            r_cnt   <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_cnt_nxt == 4'd8) begin
                r_byte  <= w_sr_nxt;
                r_valid <= 1'b1;
                r_sr    <= '0;
                r_cnt   <= '0;
            end else if (i_flush) begin
                // Partial byte: its n bits sit in the top of the shifter.
                if (w_cnt_nxt != 4'd0) begin
                    r_byte  <= w_sr_nxt >> (4'd8 - w_cnt_nxt);
                    r_valid <= 1'b1;
                end
                r_sr  <= '0;
                r_cnt <= '0;
            end else begin
                r_sr  <= w_sr_nxt;
                r_cnt <= w_cnt_nxt;
            end
        end
    end

    assign o_byte  = r_byte;
    assign o_valid = r_valid;

endmodule

// File: rtl/retospect_bs_loader.sv
// Serial configuration writer for the neurochip config chain.
// Bytes arrive on a valid/ready stream and are shifted LSB-first onto
// config_en/bs_in; bits returning on bs_ret are reassembled into rb_data.
//   clk, rst_n          : clock, async active-low reset
//   start, abort        : one-cycle control pulses
//   in_data/valid/ready : configuration byte stream
//   rb_data, rb_valid   : readback bytes (no backpressure)
//   config_en, bs_in    : registered chain drive
//   bs_ret              : chain tail
//   busy, done          : load status
//
// state | meaning
// IDLE  | waiting for start, chain untouched
// LOAD  | shifting bits, counter > 0
// FLUSH | last config_en=1 on the chain, final readback sample
module retospect_bs_loader
    import retospect_pkg::*;
#(
    parameter int CHAIN_LEN = chain_len(5, 5)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] rb_data,
    output logic       rb_valid,
    output logic       config_en,
    output logic       bs_in,
    input  logic       bs_ret,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [7:0]       r_sh_data;
    logic [3:0]       r_sh_cnt;
    logic [7:0]       r_hold_data;
    logic             r_hold_full;
    logic             r_config_en;
    logic             r_bs_in;
    logic             r_done;

    logic             w_load;
    logic             w_xfer;
    logic [7:0]       w_cur_data;
    logic             w_shift;
    logic             w_last;
    logic             w_ready;
    logic             w_accept;

    // Hold register refills an empty shift buffer in the same cycle it is
    // shifted, which keeps the stream gap-free at 1 bit/cycle.
    assign w_load     = (r_state == LOAD);
    assign w_xfer     = w_load && (r_sh_cnt == 4'd0) && r_hold_full;
    assign w_cur_data = w_xfer ? r_hold_data : r_sh_data;
    assign w_shift    = w_load && (w_xfer || (r_sh_cnt != 4'd0)) && (r_bit_cnt != '0);
    assign w_last     = w_shift && (r_bit_cnt == CNT_W'(1));
    assign w_ready    = w_load && (!r_hold_full || w_xfer) && !w_last;
    assign w_accept   = in_valid && w_ready && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) w_state_nxt = LOAD;
                LOAD:    if (w_last) w_state_nxt = FLUSH;
                FLUSH:   w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = w_ready;
        busy     = (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= '0;
            r_sh_data   <= '0;
            r_sh_cnt    <= '0;
            r_hold_data <= '0;
            r_hold_full <= 1'b0;
            r_config_en <= 1'b0;
            r_bs_in     <= 1'b0;
            r_done      <= 1'b0;
        end else if (abort) begin
            r_bit_cnt   <= '0;
            r_sh_data   <= '0;
            r_sh_cnt    <= '0;
            r_hold_data <= '0;
            r_hold_full <= 1'b0;
            r_config_en <= 1'b0;
            r_bs_in     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_config_en <= w_shift;
            r_done      <= (r_state == FLUSH);
            if (w_shift) begin
                r_bs_in   <= w_cur_data[0];
                r_sh_data <= w_cur_data >> 1;
                r_sh_cnt  <= (w_xfer ? 4'd8 : r_sh_cnt) - 4'd1;
                r_bit_cnt <= r_bit_cnt - CNT_W'(1);
            end
            if (w_accept) begin
                r_hold_data <= in_data;
                r_hold_full <= 1'b1;
            end else if (w_xfer) begin
                r_hold_full <= 1'b0;
            end
            // Outside LOAD, and once the last bit is taken, leftovers are dropped.
            if (!w_load || w_last) begin
                r_sh_cnt    <= '0;
                r_hold_full <= 1'b0;
            end
            if ((r_state == IDLE) && start) begin
                r_bit_cnt <= CNT_W'(CHAIN_LEN);
            end
        end
    end

    retospect_bs_deser u_deser (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_sample_en (r_config_en),
        .i_bit_in    (bs_ret),
        .i_flush     (r_state == FLUSH),
        .i_clear     (abort),
        .o_byte      (rb_data),
        .o_valid     (rb_valid)
    );

    assign config_en = r_config_en;
    assign bs_in     = r_bs_in;
    assign done      = r_done;

endmodule
